// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a word-serial backing-memory port.
// Defining DCACHE_STATS_EN adds the hit_count/miss_count statistics outputs.
module data_cache #(
    parameter int LINE_COUNT     = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_input_valid,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] din,
    output logic        is_ready,
    output logic        is_output_valid,
    output logic [31:0] dout,
    output logic        is_hit,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_din,
    output logic        dmem_read,
    output logic        dmem_write,
    input  logic [31:0] dmem_dout
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(LINE_COUNT);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t           state;
    state_t           state_next;
    logic [OFF_W-1:0] word_cnt;

    logic [31:0]           data_mem [LINE_COUNT*WORDS_PER_LINE];
    logic [TAG_W-1:0]      tag_mem  [LINE_COUNT];
    logic [LINE_COUNT-1:0] valid;
    logic [LINE_COUNT-1:0] dirty;

    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
    logic [TAG_W-1:0] tag;
    logic             request;
    logic             hit_done;
    logic             last_word;

    assign index     = addr[OFF_W+2 +: IDX_W];
    assign offset    = addr[2 +: OFF_W];
    assign tag       = addr[31 -: TAG_W];
    assign request   = is_input_valid && (mem_read || mem_write);
    assign is_hit    = valid[index] && (tag_mem[index] == tag);
    assign hit_done  = (state == IDLE) && request && is_hit;
    assign last_word = (word_cnt == LAST_WORD);
    assign dout      = data_mem[{index, offset}];

    always_comb begin
        state_next      = state;
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        dmem_read       = 1'b0;
        dmem_write      = 1'b0;
        dmem_addr       = '0;
        dmem_din        = '0;
        case (state)
            IDLE: begin
                is_ready = 1'b1;
                if (request) begin
                    if (is_hit)
                        is_output_valid = 1'b1;
                    else if (valid[index] && dirty[index])
                        state_next = WRITEBACK;
                    else
                        state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                dmem_write = 1'b1;
                dmem_addr  = {tag_mem[index], index, word_cnt, 2'b00};
                dmem_din   = data_mem[{index, word_cnt}];
                if (last_word)
                    state_next = ALLOCATE;
            end
            ALLOCATE: begin
                dmem_read = 1'b1;
                dmem_addr = {tag, index, word_cnt, 2'b00};
                if (last_word)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset is synchronous, so the held-reset outputs must be forced here.
        if (reset) begin
            state_next      = IDLE;
            is_ready        = 1'b1;
            is_output_valid = 1'b0;
            dmem_read       = 1'b0;
            dmem_write      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            valid    <= '0;
            dirty    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (hit_done && mem_write)
                        dirty[index] <= 1'b1;
                end
                WRITEBACK: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (last_word)
                        dirty[index] <= 1'b0;
                end
                ALLOCATE: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (last_word)
                        valid[index] <= 1'b1;
                end
                default: word_cnt <= '0;
            endcase
        end
    end

    // Arrays carry no reset; an aborted refill is harmless because valid is cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (hit_done && mem_write)
                data_mem[{index, offset}] <= din;
            if (state == ALLOCATE) begin
                data_mem[{index, word_cnt}] <= dmem_dout;
                if (last_word)
                    tag_mem[index] <= tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic in_miss;

    // The completion after a refill belongs to the miss, so it is not counted as a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            in_miss    <= 1'b0;
        end else if ((state == IDLE) && request) begin
            if (!is_hit) begin
                miss_count <= miss_count + 32'd1;
                in_miss    <= 1'b1;
            end else begin
                if (!in_miss)
                    hit_count <= hit_count + 32'd1;
                in_miss <= 1'b0;
            end
        end
    end
`endif

endmodule
